// File: rtl/if_id_queue_pkg.sv
// Shared widths and constants for the fetch/decode instruction queue.
package if_id_queue_pkg;

    localparam int ADDRESS_LEN     = 32;
    localparam int INSTRUCTION_LEN = 32;
    localparam int IFQ_DEPTH       = 4;

    localparam logic [31:0] BUBBLE_INST = 32'h0;

endpackage

// File: rtl/ifq_ptr.sv
// Wrapping queue pointer with async clear, sync clear and increment.
module ifq_ptr #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + W'(1);
        end
    end

endmodule

// File: rtl/if_id_queue.sv
// Instruction queue between fetch and decode; flushes on taken branch.
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int DEPTH  = IFQ_DEPTH,
    parameter int ADDR_W = ADDRESS_LEN,
    parameter int INST_W = INSTRUCTION_LEN,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_pc,
    input  logic [INST_W-1:0] in_instruction,
    output logic              in_ready,
    input  logic              flush,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_pc,
    output logic [INST_W-1:0] out_instruction,
    output logic [CNT_W-1:0]  count
);

    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             push;
    logic             pop;

    assign in_ready  = (count != CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    assign out_pc          = out_valid ? pc_mem[rd_ptr] : '0;
    assign out_instruction = out_valid ? inst_mem[rd_ptr]
                                       : INST_W'(BUBBLE_INST);

    ifq_ptr #(.W(PTR_W)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (pop),
        .ptr (rd_ptr)
    );

    ifq_ptr #(.W(PTR_W)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (push),
        .ptr (wr_ptr)
    );

    // Storage is intentionally unreset; validity lives in count.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= in_pc;
            inst_mem[wr_ptr] <= in_instruction;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (push && !pop) begin
            count <= count + CNT_W'(1);
        end else if (pop && !push) begin
            count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            assert (count <= CNT_W'(DEPTH))
                else $error("if_id_queue: occupancy above DEPTH");
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed scoreboard bench for the fetch/decode instruction queue.
module tb_if_id_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_pc = '0;
    logic [31:0] in_instruction = '0;
    logic        in_ready;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instruction;
    logic [2:0]  count;

    int tests = 0;
    int fails = 0;

    logic [63:0] sb[$];
    logic [31:0] last_pc;
    logic        last_ok;

    always #5 clk = ~clk;

    if_id_queue #(.DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_pc           (in_pc),
        .in_instruction  (in_instruction),
        .in_ready        (in_ready),
        .flush           (flush),
        .out_ready       (out_ready),
        .out_valid       (out_valid),
        .out_pc          (out_pc),
        .out_instruction (out_instruction),
        .count           (count)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [63:0] head;
        head = (sb.size() != 0) ? sb[0] : 64'h0;
        chk("count", 64'(count), 64'(sb.size()));
        chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
        chk("in_ready", 64'(in_ready), 64'(sb.size() != DEPTH));
        chk("out_pc", 64'(out_pc), 64'(head[63:32]));
        chk("out_inst", 64'(out_instruction), 64'(head[31:0]));
    endtask

    // One cycle: drive, check pre-edge outputs, update model at the edge.
    task automatic step(input logic iv, input logic [31:0] pc,
                        input logic [31:0] inst, input logic ordy,
                        input logic fl);
        logic m_push;
        logic m_pop;
        logic [63:0] popped;
        in_valid       = iv;
        in_pc          = pc;
        in_instruction = inst;
        out_ready      = ordy;
        flush          = fl;
        #1;
        check_outputs();
        m_push = iv && (sb.size() != DEPTH) && !fl;
        m_pop  = ordy && (sb.size() != 0) && !fl;
        @(posedge clk);
        if (fl) begin
            sb.delete();
        end else begin
            if (m_pop) begin
                popped = sb.pop_front();
                if (last_ok) begin
                    chk("pc_order", 64'(popped[63:32]), 64'(last_pc + 4));
                end
                last_pc = popped[63:32];
            end
            if (m_push) sb.push_back({pc, inst});
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 32'h0, 32'h0, ordy, 1'b0);
    endtask

    initial begin
        logic [31:0] pc;
        last_ok = 1'b0;
        last_pc = '0;

        // Reset held for two cycles
        repeat (2) begin
            @(negedge clk);
            #1;
            check_outputs();
        end
        rst = 1'b1;
        @(negedge clk);
        idle(1'b1);

        // Single push then streaming push+pop
        step(1'b1, 32'd4, 32'hE3A01001, 1'b1, 1'b0);
        chk("first_pc", 64'(out_pc), 64'd4);
        chk("first_inst", 64'(out_instruction), 64'hE3A01001);
        last_ok = 1'b1;
        last_pc = 32'd0;
        step(1'b1, 32'd8, 32'h00000008, 1'b1, 1'b0);
        step(1'b1, 32'd12, 32'h0000000C, 1'b1, 1'b0);
        chk("stream_count", 64'(count), 64'd1);
        idle(1'b1);
        idle(1'b1);

        // Stall: five pushes, only four fit
        last_pc = 32'd0;
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 32'(4 * i), $urandom, 1'b0, 1'b0);
        end
        chk("full_count", 64'(count), 64'd4);
        chk("full_ready", 64'(in_ready), 64'd0);
        idle(1'b1);
        chk("ready_after_pop", 64'(in_ready), 64'd1);
        repeat (4) idle(1'b1);

        // Wrap-around bursts of three
        pc = 32'd4;
        last_pc = 32'd0;
        for (int b = 0; b < 10; b++) begin
            for (int k = 0; k < 3; k++) begin
                step(1'b1, pc, $urandom, 1'b0, 1'b0);
                pc += 4;
            end
            repeat (3) idle(1'b1);
        end
        idle(1'b1);

        // Flush with push and pop in the same cycle
        last_ok = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 32'(100 + 4 * k), $urandom, 1'b0, 1'b0);
        end
        step(1'b1, 32'd200, 32'hDEADBEEF, 1'b1, 1'b1);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_valid", 64'(out_valid), 64'd0);
        step(1'b1, 32'h40, 32'h12345678, 1'b0, 1'b0);
        chk("target_pc", 64'(out_pc), 64'h40);
        idle(1'b1);

        // Full with pop and push: push rejected
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 32'(300 + 4 * k), $urandom, 1'b0, 1'b0);
        end
        step(1'b1, 32'd500, 32'hCAFEF00D, 1'b1, 1'b0);
        chk("full_pop_count", 64'(count), 64'd3);
        chk("full_pop_ready", 64'(in_ready), 64'd1);
        repeat (3) idle(1'b1);

        // Asynchronous reset mid-stream at count=3
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 32'(600 + 4 * k), $urandom, 1'b0, 1'b0);
        end
        chk("pre_reset_count", 64'(count), 64'd3);
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        sb.delete();
        check_outputs();
        @(negedge clk);
        rst = 1'b1;
        idle(1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
